// File: rtl/sysmgr_rst_ctl.sv
// PLL/system-manager reset sequencer: accepts soft or debounced button requests,
// pulses pll_rst after a grace delay and supervises sys_rst recovery with retries.
module sysmgr_rst_ctl #(
  parameter int unsigned DELAY_CYCLES   = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned DEBOUNCE_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_soft,
  input  logic       btn_n,
  input  logic       sys_rst,
  output logic       pll_rst,
  output logic       busy,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned MAX_DH = (DELAY_CYCLES > HOLD_CYCLES) ? DELAY_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAXC   = (MAX_DH > TIMEOUT_CYCLES) ? MAX_DH : TIMEOUT_CYCLES;
  localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD, S_WAIT} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     seen;
  logic [1:0]               btn_sync;
  logic [1:0]               srst_sync;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     btn_stable;
  logic                     btn_req;
  logic                     btn_s;
  logic                     srst_s;
  logic                     req;

  assign btn_s  = btn_sync[1];
  assign srst_s = srst_sync[1];
  assign req    = req_soft | btn_req;

  // Debounce counter only runs while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync   <= '1;
      srst_sync  <= '0;
      db_cnt     <= '0;
      btn_stable <= 1'b1;
      btn_req    <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[0], btn_n};
      srst_sync <= {srst_sync[0], sys_rst};
      btn_req   <= 1'b0;
      if (btn_s == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        db_cnt     <= '0;
        btn_stable <= btn_s;
        btn_req    <= ~btn_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seen      <= 1'b0;
      pll_rst   <= 1'b0;
      busy      <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            fail      <= 1'b0;
            retry_cnt <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          if (cnt == CW'(DELAY_CYCLES - 1)) begin
            cnt     <= '0;
            seen    <= 1'b0;
            pll_rst <= 1'b1;
            state   <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          seen <= seen | srst_s;
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt     <= '0;
            pll_rst <= 1'b0;
            state   <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          seen <= seen | srst_s;
          // Release only counts once an assertion has been observed in this attempt.
          if (seen && !srst_s) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            cnt <= '0;
            if (retry_cnt < 2'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              seen      <= 1'b0;
              pll_rst   <= 1'b1;
              state     <= S_HOLD;
            end else begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
